display_scan_controller: RTL and testbench

- Time-multiplexes the clock's BCD time fields onto one shared 7-segment decoder and a 6-digit common-anode scan bus.
- Snapshots all BCD inputs once per frame so a displayed frame never tears mid-update.
- Selects one of two display pages, inserts anti-ghosting blank gaps between digits and flags invalid BCD.
- Sits between the timekeeping counters and the board display pins.

---
 rtl/display_scan_controller_pkg.sv | 27 ++
 rtl/display_scan_controller_if.sv | 21 ++
 rtl/display_scan_controller_seg_lut.sv | 12 +
 rtl/display_scan_controller.sv | 117 +++++++++++
 tb/tb_display_scan_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the display scan controller.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
package display_pkg;
    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b1111101, 7'b1100000, 7'b0110111, 7'b1100111, 7'b1101010,
        7'b1001111, 7'b1011111, 7'b1100001, 7'b1111111, 7'b1101011
    };

    typedef enum logic [1:0] {LATCH, SHOW, BLANK} scan_state_t;
    typedef enum logic {PAGE_HMS, PAGE_SMS} page_t;

    typedef struct packed {
        logic [3:0] h1, h0, m1, m0, s1, s0, ms2, ms1, ms0;
    } bcd_time_t;

    // Only the nibbles that the page actually shows can raise an error.
    function automatic logic frame_err(input bcd_time_t t, input page_t p);
        logic shared;
        shared = (t.s1 > 4'd9) | (t.s0 > 4'd9);
        if (p == PAGE_HMS)
            return shared | (t.h1 > 4'd9) | (t.h0 > 4'd9) | (t.m1 > 4'd9) | (t.m0 > 4'd9);
        return shared | (t.ms2 > 4'd9) | (t.ms1 > 4'd9) | (t.ms0 > 4'd9);
    endfunction
endpackage

// File: rtl/display_scan_controller_if.sv
// Time-field inputs and display outputs of the scan controller.
interface display_scan_if;
    logic [3:0] hours1, hours0, minutes1, minutes0, seconds1, seconds0;
    logic [3:0] milliseconds2, milliseconds1, milliseconds0;
    logic       page_sel;
    logic [6:0] seg;
    logic [display_pkg::NUM_DIGITS-1:0] an;
    logic       frame_done;
    logic       bcd_err;

    modport master (
        output hours1, hours0, minutes1, minutes0, seconds1, seconds0,
               milliseconds2, milliseconds1, milliseconds0, page_sel,
        input  seg, an, frame_done, bcd_err
    );
    modport slave (
        input  hours1, hours0, minutes1, minutes0, seconds1, seconds0,
               milliseconds2, milliseconds1, milliseconds0, page_sel,
        output seg, an, frame_done, bcd_err
    );
endinterface

// File: rtl/display_scan_controller_seg_lut.sv
// BCD to 7-segment decoder; non-decimal nibbles decode to all segments off.
module seg_lut
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) seg = SEG_CODE[bcd];
    end
endmodule

// File: rtl/display_scan_controller.sv
// Frame-snapshotting 6-digit scan controller with two display pages.
// Define DISPLAY_SCAN_LZB_EN to blank a leading zero hours digit on page 0.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIV_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.slave bus
);
    localparam int MAXC = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]    LAST_SLOT  = 3'(NUM_DIGITS - 1);

    scan_state_t state;
    logic [2:0]  slot;
    logic [CW-1:0] cnt;
    bcd_time_t   snap, live;
    page_t       page, live_page;
    logic        started;
    logic [3:0]  nib;
    logic        blank_dig;
    logic [6:0]  lut_seg;

    assign live = {bus.hours1, bus.hours0, bus.minutes1, bus.minutes0,
                   bus.seconds1, bus.seconds0,
                   bus.milliseconds2, bus.milliseconds1, bus.milliseconds0};
    assign live_page = page_t'(bus.page_sel);

    // Digit selection from the frozen snapshot feeds the single shared decoder.
    always_comb begin
        nib       = 4'd0;
        blank_dig = 1'b0;
        if (page == PAGE_HMS) begin
            case (slot)
                3'd0:    nib = snap.h1;
                3'd1:    nib = snap.h0;
                3'd2:    nib = snap.m1;
                3'd3:    nib = snap.m0;
                3'd4:    nib = snap.s1;
                default: nib = snap.s0;
            endcase
`ifdef DISPLAY_SCAN_LZB_EN
            if (slot == 3'd0 && snap.h1 == 4'd0) blank_dig = 1'b1;
`endif
        end else begin
            case (slot)
                3'd0:    blank_dig = 1'b1;
                3'd1:    nib = snap.s1;
                3'd2:    nib = snap.s0;
                3'd3:    nib = snap.ms2;
                3'd4:    nib = snap.ms1;
                default: nib = snap.ms0;
            endcase
        end
    end

    seg_lut u_lut (.bcd(nib), .seg(lut_seg));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= LATCH;
            slot           <= 3'd0;
            cnt            <= '0;
            snap           <= '0;
            page           <= PAGE_HMS;
            started        <= 1'b0;
            bus.seg        <= SEG_BLANK;
            bus.an         <= '0;
            bus.frame_done <= 1'b0;
            bus.bcd_err    <= 1'b0;
        end else begin
            // Outputs follow the state of the cycle just ending.
            bus.an         <= (state == SHOW) ? (NUM_DIGITS'(1) << slot) : '0;
            bus.seg        <= (state == SHOW && !blank_dig) ? lut_seg : SEG_BLANK;
            bus.frame_done <= (state == LATCH) && started;
            case (state)
                LATCH: begin
                    snap        <= live;
                    page        <= live_page;
                    bus.bcd_err <= frame_err(live, live_page);
                    started     <= 1'b1;
                    slot        <= 3'd0;
                    cnt         <= '0;
                    state       <= SHOW;
                end
                SHOW: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYCLES > 0)     state <= BLANK;
                        else if (slot == LAST_SLOT) state <= LATCH;
                        else                      slot  <= slot + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt <= '0;
                        if (slot == LAST_SLOT) state <= LATCH;
                        else begin
                            slot  <= slot + 3'd1;
                            state <= SHOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= LATCH;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench: table-driven frame captures, hand sequences and a cycle-level reference model.
module tb_display_scan_controller;
    import display_pkg::*;

    localparam int D = 4;
    localparam logic [6:0] C0 = 7'b1111101, C1 = 7'b1100000, C2 = 7'b0110111, C3 = 7'b1100111,
                           C4 = 7'b1101010, C5 = 7'b1001111, C6 = 7'b1011111, C7 = 7'b1100001,
                           C8 = 7'b1111111, C9 = 7'b1101011, Z  = 7'b0000000;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam logic [6:0] LZ = Z;
`else
    localparam logic [6:0] LZ = C0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    bcd_time_t cur = '0;
    logic cur_page = 1'b0;
    int checks = 0, errors = 0;

    display_scan_if bus0 ();
    display_scan_if bus1 ();

    always_comb begin
        bus0.hours1 = cur.h1;  bus0.hours0 = cur.h0;  bus0.minutes1 = cur.m1;
        bus0.minutes0 = cur.m0; bus0.seconds1 = cur.s1; bus0.seconds0 = cur.s0;
        bus0.milliseconds2 = cur.ms2; bus0.milliseconds1 = cur.ms1; bus0.milliseconds0 = cur.ms0;
        bus0.page_sel = cur_page;
        bus1.hours1 = cur.h1;  bus1.hours0 = cur.h0;  bus1.minutes1 = cur.m1;
        bus1.minutes0 = cur.m0; bus1.seconds1 = cur.s1; bus1.seconds0 = cur.s0;
        bus1.milliseconds2 = cur.ms2; bus1.milliseconds1 = cur.ms1; bus1.milliseconds0 = cur.ms0;
        bus1.page_sel = cur_page;
    end

    display_scan_controller #(.DIV_CYCLES(D), .BLANK_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    display_scan_controller #(.DIV_CYCLES(D), .BLANK_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] lut(input logic [3:0] n);
        case (n)
            4'd0: return C0; 4'd1: return C1; 4'd2: return C2; 4'd3: return C3; 4'd4: return C4;
            4'd5: return C5; 4'd6: return C6; 4'd7: return C7; 4'd8: return C8; 4'd9: return C9;
            default: return Z;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input bcd_time_t t, input logic pg, input int s);
        logic [3:0] page0 [6];
        logic [3:0] page1 [6];
        page0 = '{t.h1, t.h0, t.m1, t.m0, t.s1, t.s0};
        page1 = '{4'hF, t.s1, t.s0, t.ms2, t.ms1, t.ms0};
        if (pg) return (s == 0) ? Z : lut(page1[s]);
`ifdef DISPLAY_SCAN_LZB_EN
        if (s == 0 && t.h1 == 4'd0) return Z;
`endif
        return lut(page0[s]);
    endfunction

    function automatic logic ref_err(input bcd_time_t t, input logic pg);
        logic [3:0] used [6];
        logic e = 1'b0;
        used = pg ? '{t.s1, t.s0, t.ms2, t.ms1, t.ms0, 4'd0} : '{t.h1, t.h0, t.m1, t.m0, t.s1, t.s0};
        foreach (used[i]) e |= (used[i] > 4'd9);
        return e;
    endfunction

    // Reference model: position inside a frame of 1 + 6*(D+B) cycles.
    int pos [2] = '{0, 0};
    bit first [2] = '{1, 1};
    bit mvalid = 0;
    bcd_time_t msnap [2];
    logic mpage [2];
    logic [5:0] e_an [2];
    logic [6:0] e_seg [2];
    logic e_fd [2], e_err [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int b, per, len, q;
            b = (k == 0) ? 2 : 0;
            per = D + b;
            len = 1 + 6 * per;
            if (reset) begin
                pos[k] = 0; first[k] = 1; msnap[k] = '0; mpage[k] = 0;
                e_an[k] = '0; e_seg[k] = Z; e_fd[k] = 0; e_err[k] = 0;
            end else if (pos[k] == 0) begin
                e_an[k] = '0; e_seg[k] = Z; e_fd[k] = !first[k]; first[k] = 0;
                msnap[k] = cur; mpage[k] = cur_page; e_err[k] = ref_err(cur, cur_page);
                pos[k] = 1;
            end else begin
                q = pos[k] - 1;
                e_fd[k] = 0;
                if (q % per < D) begin
                    e_an[k] = 6'(1) << (q / per);
                    e_seg[k] = ref_seg(msnap[k], mpage[k], q / per);
                end else begin
                    e_an[k] = '0; e_seg[k] = Z;
                end
                pos[k] = (pos[k] + 1) % len;
            end
        end
        mvalid = 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model an0", 32'(bus0.an), 32'(e_an[0]));
            chk("model seg0", 32'(bus0.seg), 32'(e_seg[0]));
            chk("model fd0", 32'(bus0.frame_done), 32'(e_fd[0]));
            chk("model err0", 32'(bus0.bcd_err), 32'(e_err[0]));
            chk("model an1", 32'(bus1.an), 32'(e_an[1]));
            chk("model seg1", 32'(bus1.seg), 32'(e_seg[1]));
            chk("model fd1", 32'(bus1.frame_done), 32'(e_fd[1]));
            chk("model err1", 32'(bus1.bcd_err), 32'(e_err[1]));
        end
    end

    typedef struct packed {
        bcd_time_t        t;
        logic             page;
        logic [0:5][6:0]  segs;
        logic             err;
    } row_t;
    row_t rows [7];

    task automatic wait_fd0(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus0.frame_done && n < 200);
        if (!bus0.frame_done) chk({name, " timeout"}, 32'(n), 32'd0);
    endtask

    task automatic wait_an0(input logic [5:0] pat, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus0.an !== pat && n < 200);
        if (bus0.an !== pat) chk({name, " timeout"}, 32'(bus0.an), 32'(pat));
    endtask

    // Releases reset and measures cycles to the first frame_done pulse of each DUT.
    task automatic release_and_measure();
        int n0 = 0, n1 = 0;
        reset = 1'b0;
        for (int n = 1; n <= 100 && (n0 == 0 || n1 == 0); n++) begin
            @(negedge clk);
            if (bus0.frame_done && n0 == 0) n0 = n;
            if (bus1.frame_done && n1 == 0) n1 = n;
        end
        chk("first fd dut0", 32'(n0), 32'd38);
        chk("first fd dut1", 32'(n1), 32'd26);
    endtask

    task automatic run_row(input int idx);
        logic [6:0] got [6];
        int lit [6];
        int n = 0;
        logic err_seen;
        cur = rows[idx].t;
        cur_page = rows[idx].page;
        wait_fd0($sformatf("row%0d sync", idx));
        foreach (lit[i]) begin lit[i] = 0; got[i] = 7'h7F; end
        err_seen = bus0.bcd_err;
        do begin
            @(negedge clk); n++;
            for (int s = 0; s < 6; s++)
                if (bus0.an == 6'(1) << s) begin lit[s]++; got[s] = bus0.seg; end
        end while (!bus0.frame_done && n < 100);
        chk($sformatf("row%0d frame len", idx), 32'(n), 32'd37);
        chk($sformatf("row%0d bcd_err", idx), 32'(err_seen), 32'(rows[idx].err));
        for (int s = 0; s < 6; s++) begin
            chk($sformatf("row%0d slot%0d seg", idx, s), 32'(got[s]), 32'(rows[idx].segs[s]));
        end
        chk($sformatf("row%0d lit cycles", idx),
            32'(lit[0] + lit[1] + lit[2] + lit[3] + lit[4] + lit[5]), 32'(6 * D));
    endtask

    initial begin
        rows[0] = '{36'h123456000, 1'b0, {C1, C2, C3, C4, C5, C6}, 1'b0};
        rows[1] = '{36'h123459123, 1'b1, {Z, C5, C9, C1, C2, C3}, 1'b0};
        rows[2] = '{36'h123C56000, 1'b0, {C1, C2, C3, Z, C5, C6}, 1'b1};
        rows[3] = '{36'h123456000, 1'b0, {C1, C2, C3, C4, C5, C6}, 1'b0};
        rows[4] = '{36'h080000000, 1'b0, {LZ, C8, C0, C0, C0, C0}, 1'b0};
        rows[5] = '{36'hA00007F05, 1'b1, {Z, C0, C7, Z, C0, C5}, 1'b1};
        rows[6] = '{36'hE00042999, 1'b1, {Z, C4, C2, C9, C9, C9}, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset an", 32'(bus0.an), 32'd0);
        chk("reset seg", 32'(bus0.seg), 32'd0);
        chk("reset fd", 32'(bus0.frame_done), 32'd0);
        chk("reset err", 32'(bus0.bcd_err), 32'd0);
        cur = rows[0].t;
        release_and_measure();

        for (int i = 0; i < 7; i++) run_row(i);

        // Mid-frame edits must not show until the next frame.
        cur = rows[0].t; cur_page = 1'b0;
        wait_fd0("toggle sync");
        repeat (3) @(negedge clk);
        cur.h0 = 4'd9; cur_page = 1'b1;
        wait_an0(6'b000010, "toggle old");
        chk("mid-frame hold slot1", 32'(bus0.seg), 32'(C2));
        wait_fd0("toggle next");
        wait_an0(6'b000010, "toggle new");
        chk("next frame page1 slot1", 32'(bus0.seg), 32'(C5));

        // Reset during slot 3.
        cur_page = 1'b0;
        wait_fd0("rst sync");
        wait_an0(6'b001000, "rst slot3");
        reset = 1'b1;
        @(negedge clk);
        chk("midreset an", 32'(bus0.an), 32'd0);
        chk("midreset seg", 32'(bus0.seg), 32'd0);
        chk("midreset fd", 32'(bus0.frame_done), 32'd0);
        chk("midreset err", 32'(bus0.bcd_err), 32'd0);
        release_and_measure();

        // Randomized inputs and page changes, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bcd_time_t t;
                for (int f = 0; f < 9; f++)
                    t[f*4 +: 4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                             : 4'($urandom_range(10, 15));
                if ($urandom_range(0, 3) == 0) t.h1 = 4'd0;
                cur = t;
            end
            if ($urandom_range(0, 19) == 0) cur_page = ~cur_page;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
